memory_stage_lsu: RTL and testbench

//  Load/store unit for the Memory stage of the pipelined RV32I core.
//  - Fed by the Execute->Memory register; sits between it and the Writeback data register.
//  - Runs a req/ack data-memory handshake and stalls the pipeline while a request is pending.
//  - Produces store byte-lanes and sign/zero-extended load data (ReadDataM for writeback).
//  - Flags misaligned accesses, illegal accesses and bus timeouts.

---
 rtl/memory_stage_lsu.sv | 156 +++++++++++++++
 tb/tb_memory_stage_lsu.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage_lsu.sv
// Memory-stage load/store unit: decodes the M-stage access, runs a req/ack data-memory handshake
// (IDLE -> WAIT -> DONE, minimum 3 cycles) and holds o_StallM high until the DONE cycle.
module memory_stage_lsu #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic        i_MemReadM,
  input  logic        i_MemWriteM,
  input  logic [2:0]  i_Funct3M,
  input  logic [31:0] i_ALUResultM,
  input  logic [31:0] i_WriteDataM,
  input  logic        i_MemAck,
  input  logic [31:0] i_MemRData,
  output logic        o_MemReq,
  output logic        o_MemWe,
  output logic [31:0] o_MemAddr,
  output logic [31:0] o_MemWData,
  output logic [3:0]  o_MemBE,
  output logic        o_StallM,
  output logic [31:0] o_ReadDataM,
  output logic        o_MisalignM,
  output logic        o_IllegalM,
  output logic        o_BusErrM
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       lat_funct3;
  logic [1:0]       lat_off;
  logic             lat_load;

  logic        access, f3_ok, illegal, misalign, in_idle, start;
  logic [31:0] lane_wdata, shifted, load_val;
  logic [3:0]  lane_be;

  always_comb begin
    access  = i_MemReadM | i_MemWriteM;
    in_idle = (state == S_IDLE);
    case (i_Funct3M)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = i_MemReadM;
      default:                f3_ok = 1'b0;
    endcase
    // Illegal wins over misaligned, so misalign is only raised for otherwise-legal accesses.
    illegal  = access & ((i_MemReadM & i_MemWriteM) | ~f3_ok);
    misalign = access & ~illegal &
               (((i_Funct3M[1:0] == 2'b01) & i_ALUResultM[0]) |
                ((i_Funct3M[1:0] == 2'b10) & (|i_ALUResultM[1:0])));
    start    = in_idle & access & ~illegal & ~misalign;
  end

  assign o_IllegalM  = in_idle & illegal;
  assign o_MisalignM = in_idle & misalign;
  assign o_StallM    = start | (state == S_WAIT);

  always_comb begin
    lane_wdata = i_WriteDataM;
    lane_be    = 4'b1111;
    if (i_MemWriteM) begin
      case (i_Funct3M[1:0])
        2'b00: begin
          lane_wdata = {4{i_WriteDataM[7:0]}};
          lane_be    = 4'b0001 << i_ALUResultM[1:0];
        end
        2'b01: begin
          lane_wdata = {2{i_WriteDataM[15:0]}};
          lane_be    = i_ALUResultM[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          lane_wdata = i_WriteDataM;
          lane_be    = 4'b1111;
        end
      endcase
    end
  end

  // Extraction works from the IDLE-cycle snapshot; the M-stage inputs may change while stalled.
  always_comb begin
    shifted  = i_MemRData >> {lat_off, 3'b000};
    load_val = '0;
    if (lat_load) begin
      case (lat_funct3)
        3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
        3'b100:  load_val = {24'b0, shifted[7:0]};
        3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
        3'b101:  load_val = {16'b0, shifted[15:0]};
        default: load_val = i_MemRData;
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      lat_funct3  <= '0;
      lat_off     <= '0;
      lat_load    <= 1'b0;
      o_MemReq    <= 1'b0;
      o_MemWe     <= 1'b0;
      o_MemAddr   <= '0;
      o_MemWData  <= '0;
      o_MemBE     <= '0;
      o_ReadDataM <= '0;
      o_BusErrM   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (start) begin
            o_MemReq   <= 1'b1;
            o_MemWe    <= i_MemWriteM;
            o_MemAddr  <= {i_ALUResultM[31:2], 2'b00};
            o_MemWData <= lane_wdata;
            o_MemBE    <= lane_be;
            lat_funct3 <= i_Funct3M;
            lat_off    <= i_ALUResultM[1:0];
            lat_load   <= i_MemReadM;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt + CNT_W'(1);
          if (i_MemAck) begin
            o_MemReq    <= 1'b0;
            o_ReadDataM <= load_val;
            state       <= S_DONE;
          end else if (cnt == CNT_LAST) begin
            o_MemReq    <= 1'b0;
            o_ReadDataM <= '0;
            o_BusErrM   <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          cnt         <= '0;
          o_ReadDataM <= '0;
          o_BusErrM   <= 1'b0;
          state       <= S_IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage_lsu.sv
// Scoreboard bench for memory_stage_lsu: driver pushes expectations, monitor pops on DUT events.
module tb_memory_stage_lsu;

  localparam int TO = 4;

  logic        i_Clk = 1'b0;
  logic        i_Reset = 1'b1;
  logic        i_MemReadM = 1'b0;
  logic        i_MemWriteM = 1'b0;
  logic [2:0]  i_Funct3M = '0;
  logic [31:0] i_ALUResultM = '0;
  logic [31:0] i_WriteDataM = '0;
  logic        i_MemAck = 1'b0;
  logic [31:0] i_MemRData = '0;
  logic        o_MemReq, o_MemWe, o_StallM, o_MisalignM, o_IllegalM, o_BusErrM;
  logic [31:0] o_MemAddr, o_MemWData, o_ReadDataM;
  logic [3:0]  o_MemBE;

  memory_stage_lsu #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_MemReadM(i_MemReadM), .i_MemWriteM(i_MemWriteM),
    .i_Funct3M(i_Funct3M), .i_ALUResultM(i_ALUResultM), .i_WriteDataM(i_WriteDataM),
    .i_MemAck(i_MemAck), .i_MemRData(i_MemRData), .o_MemReq(o_MemReq), .o_MemWe(o_MemWe),
    .o_MemAddr(o_MemAddr), .o_MemWData(o_MemWData), .o_MemBE(o_MemBE), .o_StallM(o_StallM),
    .o_ReadDataM(o_ReadDataM), .o_MisalignM(o_MisalignM), .o_IllegalM(o_IllegalM),
    .o_BusErrM(o_BusErrM)
  );

  always #5 i_Clk = ~i_Clk;

  // kind: 0 = fault flag, 1 = request issued, 2 = access completed
  typedef struct {
    int          kind;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        mis;
    logic        ill;
    logic [31:0] rdata;
    logic        buserr;
    int          waits;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          ack_delay = 0;
  logic        ack_en = 1'b0;
  logic        force_ack = 1'b0;
  logic [31:0] resp_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pop_exp(input int kind, output exp_t e, output bit ok);
    ok = 1'b0;
    e  = '{kind: -1, we: 1'b0, addr: '0, wdata: '0, be: '0, mis: 1'b0, ill: 1'b0,
           rdata: '0, buserr: 1'b0, waits: 0};
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected event kind %0d: got DUT event expected none at %0t", kind, $time);
    end else begin
      e = sb.pop_front();
      check("event kind", e.kind, kind);
      ok = (e.kind == kind);
    end
  endtask

  // Memory responder: acks after ack_delay WAIT cycles, or only on force_ack outside a request.
  initial begin : responder
    int wcnt;
    wcnt = 0;
    forever begin
      @(negedge i_Clk);
      #1;
      if (o_MemReq) begin
        if (ack_en && wcnt == ack_delay) begin
          i_MemAck   = 1'b1;
          i_MemRData = resp_data;
        end else begin
          i_MemAck   = 1'b0;
          i_MemRData = $urandom;
        end
        wcnt++;
      end else begin
        wcnt       = 0;
        i_MemAck   = force_ack;
        i_MemRData = $urandom;
      end
    end
  end

  initial begin : monitor
    logic        prev_req, prev_rst, prev_stall, p_we;
    logic [31:0] p_addr, p_wdata;
    logic [3:0]  p_be;
    int          req_cycles;
    exp_t        e;
    bit          ok;
    prev_req = 1'b0; prev_rst = 1'b0; prev_stall = 1'b0; p_we = 1'b0;
    p_addr = '0; p_wdata = '0; p_be = '0; req_cycles = 0;
    forever begin
      @(negedge i_Clk);
      #3;
      if (prev_rst) begin
        check("reset req", 32'(o_MemReq), 32'd0);
        check("reset we/be", 32'({o_MemWe, o_MemBE}), 32'd0);
        check("reset addr", o_MemAddr, 32'd0);
        check("reset wdata", o_MemWData, 32'd0);
        check("reset readdata", o_ReadDataM, 32'd0);
        check("reset buserr", 32'(o_BusErrM), 32'd0);
        check("reset stall", 32'(o_StallM), 32'd0);
      end else if (prev_req && !o_MemReq) begin
        pop_exp(2, e, ok);
        if (ok) begin
          check("done readdata", o_ReadDataM, e.rdata);
          check("done buserr", 32'(o_BusErrM), 32'(e.buserr));
          check("done stall", 32'(o_StallM), 32'd0);
          check("req cycles", req_cycles, e.waits);
        end
      end
      if (o_MemReq && !prev_req) begin
        pop_exp(1, e, ok);
        if (ok) begin
          check("req we", 32'(o_MemWe), 32'(e.we));
          check("req addr", o_MemAddr, e.addr);
          check("req be", 32'(o_MemBE), 32'(e.be));
          if (e.we) check("req wdata", o_MemWData, e.wdata);
          check("idle stall", 32'(prev_stall), 32'd1);
        end
        p_we = o_MemWe; p_addr = o_MemAddr; p_wdata = o_MemWData; p_be = o_MemBE;
        req_cycles = 1;
      end else if (o_MemReq) begin
        req_cycles++;
        check("hold addr", o_MemAddr, p_addr);
        check("hold we/be", 32'({o_MemWe, o_MemBE}), 32'({p_we, p_be}));
        check("hold wdata", o_MemWData, p_wdata);
        check("wait stall", 32'(o_StallM), 32'd1);
      end
      if (!o_MemReq && !prev_req && !prev_rst) begin
        check("idle readdata", o_ReadDataM, 32'd0);
        check("idle buserr", 32'(o_BusErrM), 32'd0);
      end
      if (o_MisalignM || o_IllegalM) begin
        pop_exp(0, e, ok);
        if (ok) begin
          check("misalign", 32'(o_MisalignM), 32'(e.mis));
          check("illegal", 32'(o_IllegalM), 32'(e.ill));
          check("fault stall", 32'(o_StallM), 32'd0);
          check("fault req", 32'(o_MemReq), 32'd0);
        end
      end
      prev_req = o_MemReq; prev_rst = i_Reset; prev_stall = o_StallM;
    end
  end

  task automatic set_idle();
    i_MemReadM = 1'b0; i_MemWriteM = 1'b0;
  endtask

  // Reference model from the access rules; drives one access and returns on its last cycle.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input int dly, input logic [31:0] rw, input logic aen);
    exp_t        e;
    int          sz, off, c;
    logic        legal, tout, fin;
    logic [31:0] v, mask;
    sz  = 1 << f3[1:0];
    off = int'(a[1:0]);
    legal = rd ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
    if (rd && wr) legal = 1'b0;
    e = '{kind: 0, we: wr, addr: a & 32'hFFFF_FFFC, wdata: '0, be: '0, mis: 1'b0, ill: 1'b0,
          rdata: '0, buserr: 1'b0, waits: 0};
    @(negedge i_Clk);
    if (!legal || (off % sz) != 0) begin
      e.ill = !legal;
      e.mis = legal;
      sb.push_back(e);
      i_MemReadM = rd; i_MemWriteM = wr; i_Funct3M = f3; i_ALUResultM = a; i_WriteDataM = d;
      @(negedge i_Clk);
      set_idle();
      return;
    end
    e.kind = 1;
    for (int i = 0; i < 4; i++) begin
      e.be[i] = wr ? (i >= off && i < off + sz) : 1'b1;
      e.wdata[8*i +: 8] = d[8*(i % sz) +: 8];
    end
    sb.push_back(e);
    tout    = !aen || dly >= TO;
    e.kind  = 2;
    e.waits = tout ? TO : dly + 1;
    e.buserr = tout;
    v = rw >> (8 * off);
    if (sz < 4) begin
      mask = (32'h1 << (8 * sz)) - 32'h1;
      v = v & mask;
      if (!f3[2] && v[8*sz-1]) v = v | ~mask;
    end
    e.rdata = (wr || tout) ? 32'd0 : v;
    sb.push_back(e);
    ack_delay = dly; ack_en = aen; resp_data = rw;
    i_MemReadM = rd; i_MemWriteM = wr; i_Funct3M = f3; i_ALUResultM = a; i_WriteDataM = d;
    c = 0;
    fin = 1'b0;
    while (!fin && c < 4 * TO + 8) begin
      @(negedge i_Clk);
      c++;
      if (!o_StallM) fin = 1'b1;
      else begin
        i_Funct3M = 3'($urandom); i_ALUResultM = $urandom; i_WriteDataM = $urandom;
      end
    end
    if (!fin) begin
      n_cmp++;
      n_bad++;
      $display("FAIL stall release: got stall stuck for %0d cycles expected release", c);
    end
    set_idle();
  endtask

  initial begin : driver
    exp_t e;
    int   r;
    repeat (3) @(negedge i_Clk);
    i_Reset = 1'b0;

    access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 1, 32'hDEADBEEF, 1'b1);
    access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80123456, 1'b1);
    access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 0, 32'h80123456, 1'b1);
    access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 0, 32'h80011234, 1'b1);
    access(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 2, 32'h80011234, 1'b1);
    access(1'b0, 1'b1, 3'b000, 32'h101, 32'h12345678, 0, 32'h0, 1'b1);
    access(1'b0, 1'b1, 3'b001, 32'h102, 32'h12345678, 1, 32'h0, 1'b1);
    access(1'b0, 1'b1, 3'b010, 32'h104, 32'hCAFEF00D, 3, 32'h0, 1'b1);
    access(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 0, 32'h0, 1'b1);
    access(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 0, 32'h0, 1'b1);
    access(1'b1, 1'b1, 3'b010, 32'h100, 32'h0, 0, 32'h0, 1'b1);
    access(1'b0, 1'b1, 3'b100, 32'h100, 32'h0, 0, 32'h0, 1'b1);
    access(1'b0, 1'b1, 3'b001, 32'h101, 32'h0, 0, 32'h0, 1'b1);

    // Timeout, then an ack during DONE and the following IDLE cycle that must be ignored.
    access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 0, 32'h11111111, 1'b0);
    force_ack = 1'b1;
    repeat (2) @(negedge i_Clk);
    force_ack = 1'b0;

    // Reset during the second WAIT cycle; the ack one cycle later must not start anything.
    e = '{kind: 1, we: 1'b0, addr: 32'h200, wdata: '0, be: 4'hF, mis: 1'b0, ill: 1'b0,
          rdata: '0, buserr: 1'b0, waits: 0};
    sb.push_back(e);
    ack_en = 1'b0;
    @(negedge i_Clk);
    i_MemReadM = 1'b1; i_Funct3M = 3'b010; i_ALUResultM = 32'h200;
    repeat (2) @(negedge i_Clk);
    i_Reset = 1'b1;
    @(negedge i_Clk);
    i_Reset = 1'b0;
    set_idle();
    force_ack = 1'b1;
    @(negedge i_Clk);
    force_ack = 1'b0;
    access(1'b1, 1'b0, 3'b010, 32'h204, 32'h0, 1, 32'h0BADF00D, 1'b1);

    for (int n = 0; n < 250; n++) begin
      logic        rd, wr;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      rd = (r < 6);
      wr = (r >= 6) || (r == 0 && $urandom_range(0, 1) == 1);
      a = $urandom;
      if ($urandom_range(0, 2) == 0) a[1:0] = 2'b00;
      access(rd, wr, 3'($urandom), a, $urandom, $urandom_range(0, TO + 1), $urandom,
             $urandom_range(0, 7) != 0);
    end

    repeat (3) @(negedge i_Clk);
    check("scoreboard drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
